// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared UART definitions: transmitter FSM encoding and line levels.
// The IDLE_LEVEL / START_LEVEL constants are also used by the RX block.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divisor: counts 0..last_i and emits a one-cycle tick on the
// final count of each bit period. restart_i holds the counter at zero.
module uart_baud_tick #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count, wrap to zero on tick or restart.
  always_comb begin
    tick_o = !restart_i && (cnt_q == last_i);
    cnt_d  = cnt_q + CNT_W'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register, asynchronous active-high reset.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining the TX FIFO: pops a word from IDLE, captures it
// in LOAD, then serialises start / data (LSB first) / optional parity / stop.
// Optional parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif

  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx_fifo_drain: unsupported parameter set");
  end

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  tx_q, tx_d;
  logic                  baud_restart;
  logic                  baud_tick;
  logic [CNT_W-1:0]      baud_last;

`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // Baud counter runs only while a serial bit is on the line.
  assign baud_restart = (state_q == IDLE) || (state_q == LOAD);
  assign baud_last    = (state_q == STOP) ? STOP_LAST : BIT_LAST;

  uart_baud_tick #(
    .CNT_W (CNT_W)
  ) u_baud (
    .clock     (clock),
    .resetn    (resetn),
    .restart_i (baud_restart),
    .last_i    (baud_last),
    .tick_o    (baud_tick)
  );

  // State register, asynchronous active-high reset back to IDLE.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: advance on pop, after LOAD, and on bit-period ticks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_pop) state_d = LOAD;
      LOAD:    state_d = START;
      START:   if (baud_tick) state_d = DATA;
      DATA:    if (baud_tick && (bit_idx_q == DATA_LAST)) state_d = AFTER_DATA;
      PARITY:  if (baud_tick) state_d = STOP;
      STOP:    if (baud_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values; tx is precomputed from the state being
  // entered so the registered line changes exactly on state/bit boundaries.
  always_comb begin
    fifo_pop  = !resetn && (state_q == IDLE) && tx_enable && !fifo_empty;
    busy      = (state_q != IDLE);
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    if (state_q == LOAD) begin
      shift_d   = fifo_data;
      bit_idx_d = '0;
    end else if ((state_q == DATA) && baud_tick) begin
      shift_d   = shift_q >> 1;
      bit_idx_d = bit_idx_q + BIT_W'(1);
    end
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
    if (state_q == LOAD) begin
      parity_d = (^fifo_data) ^ 1'(PARITY_ODD);
    end
`endif
    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  // Datapath registers: shift register, bit index and the registered line.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= IDLE_LEVEL;
    end else begin
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the captured word, held for the PARITY bit.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx = tx_q;

endmodule
